// File: rtl/doodle_pkg.sv
// Shared doodle definitions: FSM states, screen geometry and keyboard codes.
package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the VGA vertical sync into the Clk domain and emits a one-Clk tick per rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= frame_clk;
      sync2      <= sync1;
      sync2_d    <= sync2;
      frame_tick <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/doodle_motion.sv
// Per-frame doodle motion: gravity, platform landing, steering, edge wrap and death.
module doodle_motion
  import doodle_pkg::*;
#(
  parameter int START_X  = 320,
  parameter int START_Y  = 240,
  parameter int DOODLE_W = 8,
  parameter int DOODLE_H = 16,
  parameter int PLAT_W   = 64,
  parameter int JUMP_V   = 12,
  parameter int MAX_FALL = 10,
  parameter int STEP_X   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] PlatX,
  input  logic [9:0] PlatY,
  output logic [9:0] DoodleX,
  output logic [9:0] DoodleY,
  output logic [7:0] DoodleVY,
  output logic [1:0] state_o,
  output logic       land_p,
  output logic       dead_p
);

  localparam logic signed [10:0] VRES_S = 11'(V_RES);
  localparam logic signed [10:0] HRES_S = 11'(H_RES);
  localparam logic signed [10:0] DH_S   = 11'(DOODLE_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP_X);
  localparam logic [10:0]        DW_U   = 11'(DOODLE_W);
  localparam logic [10:0]        PW_U   = 11'(PLAT_W);
  localparam logic signed [7:0]  JUMP_S = 8'(JUMP_V);
  localparam logic signed [7:0]  MAXF_S = 8'(MAX_FALL);

  logic frame_tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [7:0] vy_q, vy_d;
  logic              land_d, dead_d;

  logic signed [10:0] y_s, y_sum, bot_old, bot_new, plat_y_s, x_s, x_mv;
  logic signed [7:0]  vy_inc, vy_nxt;
  logic               overlap, landing;

  always_comb begin
    y_s      = signed'({1'b0, y_q});
    y_sum    = y_s + 11'(vy_q);
    bot_old  = y_s + DH_S;
    bot_new  = y_sum + DH_S;
    plat_y_s = signed'({1'b0, PlatY});
    // Overlap and landing use the X held before this tick's steering move.
    overlap  = (({1'b0, x_q} + DW_U) > {1'b0, PlatX}) &&
               ({1'b0, x_q} < ({1'b0, PlatX} + PW_U));
    landing  = (state_q == FALL) && (vy_q > 8'sd0) &&
               (bot_old <= plat_y_s) && (bot_new >= plat_y_s) && overlap;

    vy_inc = vy_q + 8'sd1;
    vy_nxt = (vy_inc > MAXF_S) ? MAXF_S : vy_inc;

    x_s  = signed'({1'b0, x_q});
    x_mv = x_s;
    if (keycode == KEY_A)      x_mv = x_s - STEP_S;
    else if (keycode == KEY_D) x_mv = x_s + STEP_S;
    if (x_mv < 11'sd0)         x_mv = x_mv + HRES_S;
    else if (x_mv >= HRES_S)   x_mv = x_mv - HRES_S;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    land_d  = 1'b0;
    dead_d  = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (keycode == KEY_SPACE) begin
            state_d = RISE;
            vy_d    = -JUMP_S;
          end
        end
        RISE, FALL: begin
          if (landing) begin
            state_d = RISE;
            x_d     = x_mv[9:0];
            y_d     = 10'(plat_y_s - DH_S);
            vy_d    = -JUMP_S;
            land_d  = 1'b1;
          end else if ((state_q == FALL) && (y_sum >= VRES_S)) begin
            state_d = DEAD;
            dead_d  = 1'b1;
          end else begin
            x_d = x_mv[9:0];
            if (y_sum < 11'sd0) begin
              y_d     = '0;
              vy_d    = '0;
              state_d = FALL;
            end else begin
              y_d  = y_sum[9:0];
              vy_d = vy_nxt;
              if (vy_nxt >= 8'sd0) state_d = FALL;
            end
          end
        end
        DEAD: begin
          if (keycode == KEY_SPACE) begin
            state_d = IDLE;
            x_d     = 10'(START_X);
            y_d     = 10'(START_Y);
            vy_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      vy_q    <= '0;
      land_p  <= 1'b0;
      dead_p  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      land_p  <= land_d;
      dead_p  <= dead_d;
    end
  end

  assign DoodleX  = x_q;
  assign DoodleY  = y_q;
  assign DoodleVY = vy_q;
  assign state_o  = state_q;

endmodule

// File: doc/doodle_motion.md
# doodle_motion

Per-frame motion engine for the doodle sprite. Samples the vertical-sync frame clock, applies gravity, platform landing, horizontal steering from the USB keycode, and screen-edge wrap. Drives DoodleX/DoodleY into color_mapper, which renders the 8x16 sprite at that position. Sits between the keyboard/platform logic and color_mapper, in the pixel clock domain.

## Interface
Parameters:
- START_X, 320, reset/restart X position (pixels, top-left corner)
- START_Y, 240, reset/restart Y position
- DOODLE_W, 8, sprite width
- DOODLE_H, 16, sprite height
- PLAT_W, 64, platform width
- JUMP_V, 12, magnitude of launch velocity (pixels/frame, upward)
- MAX_FALL, 10, terminal downward velocity
- STEP_X, 2, horizontal pixels per frame while a steer key is held

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  vertical sync from VGA controller, asynchronous to Clk
- keycode  in  8  current USB HID keycode (0 = none)
- PlatX  in  10  platform top-left X
- PlatY  in  10  platform top-left Y
- DoodleX  out  10  sprite top-left X
- DoodleY  out  10  sprite top-left Y
- DoodleVY  out  8  signed vertical velocity, positive = down
- state_o  out  2  current FSM state encoding
- land_p  out  1  one-Clk pulse on platform landing
- dead_p  out  1  one-Clk pulse on entry to DEAD

## Operation
- frame_clk passes a 2-flop synchronizer, then rising-edge detect -> frame_tick (one Clk wide). All motion updates occur only on frame_tick.
- FSM states: IDLE=0, RISE=1, FALL=2, DEAD=3.
- IDLE: position held at START. Keycode 0x2C (space) on frame_tick -> RISE, VY = -JUMP_V.
- RISE/FALL each tick: VY_next = min(VY + 1, MAX_FALL); Y_next = Y + VY (11-bit signed internal arithmetic, no truncation before compare). RISE -> FALL when VY_next >= 0.
- Y_next < 0 clamps Y to 0 and forces VY = 0 (ceiling).
- Landing (FALL only, VY > 0): bottom = Y + DOODLE_H. If bottom_old <= PlatY and bottom_new >= PlatY and X + DOODLE_W > PlatX and X < PlatX + PLAT_W, then Y = PlatY - DOODLE_H, VY = -JUMP_V, state RISE, land_p pulses. Landing takes priority over death in the same tick.
- Death: in FALL, Y_next >= 480 -> DEAD, dead_p pulses, position frozen. DEAD + space on tick -> IDLE with START position, VY = 0.
- Horizontal (RISE/FALL only): keycode 0x04 (A) X -= STEP_X; 0x07 (D) X += STEP_X; other codes no move. Wrap: X < 0 -> X + 640; X >= 640 -> X - 640. Landing test uses pre-move X.

## Timing
- Reset values: DoodleX = START_X, DoodleY = START_Y, DoodleVY = 0, state_o = IDLE, land_p = dead_p = 0; synchronizer flops 0.
- frame_clk edge to frame_tick: 3 Clk (2 sync + edge register). Outputs update on the Clk after frame_tick; stable for the rest of the frame.
- Outputs registered; no combinational path from keycode/PlatX/PlatY to outputs.
- keycode sampled only at frame_tick; changes between ticks ignored.
- Reset_n asserted mid-frame returns all outputs to reset values immediately (asynchronously); first tick after release acts from IDLE.
- Successive frame_clk edges closer than 4 Clk are unsupported.

## Structure
- Shared package doodle_pkg: state enum (IDLE, RISE, FALL, DEAD), screen constants H_RES=640, V_RES=480, keycode constants KEY_A=8'h04, KEY_D=8'h07, KEY_SPACE=8'h2C. color_mapper imports the same screen constants.
- One sub-module: frame_tick_gen (2-flop synchronizer + rising-edge detector, Reset_n async clear).

## Test plan
- Reset then 10 frames, keycode 0 -> DoodleX=320, DoodleY=240, state IDLE, DoodleVY=0.
- Space on frame 1, no platform under path -> VY sequence -12,-11,...; Y after tick 1 = 228; state RISE -> FALL when VY reaches 0; eventually dead_p pulses once, Y frozen, state DEAD.
- PlatX=300, PlatY=300, doodle falling from Y=240 -> land_p pulses, DoodleY=284, DoodleVY=-12, state RISE.
- Same fall with PlatX=400 (no overlap) -> no landing, doodle passes through to DEAD.
- Held D with X=638 in RISE -> next tick X=0; held A at X=0 -> X=638.
- Reset_n pulsed mid-RISE between ticks -> outputs return to 320/240/0/IDLE without waiting for Clk edge.
